if_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU: owns the program counter, issues word fetches to instruction memory over a req/ready handshake, and delivers the `pc4`/`inst` pair into the IF/ID pipeline register consumed by the decode stage. It is the opposite end of the decode stage's `bpc`/`jpc`/`pcsource` redirect interface. It absorbs variable memory latency, decode stalls (one-entry skid buffer) and taken branches/jumps (squash plus in-flight drain).

---
 rtl/if_fetch_stage_if.sv | 22 ++
 rtl/if_fetch_stage.sv | 130 +++++++++++++
 tb/tb_if_fetch_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch channel: request/ready handshake with address and returned word.
// The fetch stage drives req/addr (master); the memory answers with ready/rdata (slave).
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Purpose: PC ownership, imem fetch, IF/ID register with one-entry skid and redirect squash/drain.
// Latency: memory data returned in cycle N is on inst/pc4 in cycle N+1; zero-wait gives 1 inst/cycle.
// Backpressure: id_stall holds IF/ID, one extra fetch lands in the skid, then imem_req drops until release.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            pcsource,
    input  logic [31:0]           bpc,
    input  logic [31:0]           jpc,
    input  logic                  id_stall,
    if_fetch_stage_if.master      imem,
    output logic [31:0]           pc,
    output logic [31:0]           pc4,
    output logic [31:0]           inst,
    output logic                  inst_valid
);

    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_d;
    logic [31:0] stale_addr_q, stale_addr_d;
    logic [31:0] pc4_d, inst_d;
    logic        inst_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    logic        xfer, consume, redirect, if_free;
    logic [31:0] target, pc_plus4;

    assign imem.imem_req  = !rst && (state_q != HOLD);
    assign imem.imem_addr = (state_q == DRAIN) ? stale_addr_q : pc;

    assign xfer     = imem.imem_req && imem.imem_ready;
    assign consume  = inst_valid && !id_stall;
    // pcsource 01 and 11 redirect; 10 is reserved and behaves as sequential
    assign redirect = consume && pcsource[0];
    assign target   = (pcsource[1] ? jpc : bpc) & 32'hFFFF_FFFC;
    assign if_free  = !inst_valid || !id_stall;
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc           <= RESET_PC;
            stale_addr_q <= 32'h0;
            pc4          <= 32'h0;
            inst         <= 32'h0;
            inst_valid   <= 1'b0;
            skid_inst_q  <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc           <= pc_d;
            stale_addr_q <= stale_addr_d;
            pc4          <= pc4_d;
            inst         <= inst_d;
            inst_valid   <= inst_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc;
        stale_addr_d = stale_addr_q;
        pc4_d        = pc4;
        inst_d       = inst;
        inst_valid_d = inst_valid;
        skid_inst_d  = skid_inst_q;
        skid_pc4_d   = skid_pc4_q;

        case (state_q)
            FETCH: begin
                if (redirect) begin
                    inst_d       = 32'h0;
                    inst_valid_d = 1'b0;
                    pc_d         = target;
                    // a fetch still in flight must be allowed to finish before the target goes out
                    if (!xfer) begin
                        stale_addr_d = pc;
                        state_d      = DRAIN;
                    end
                end else if (xfer && if_free) begin
                    inst_d       = imem.imem_rdata;
                    pc4_d        = pc_plus4;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_plus4;
                end else if (xfer) begin
                    skid_inst_d  = imem.imem_rdata;
                    skid_pc4_d   = pc_plus4;
                    pc_d         = pc_plus4;
                    state_d      = HOLD;
                end else if (if_free) begin
                    inst_d       = 32'h0;
                    inst_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                inst_d       = 32'h0;
                inst_valid_d = 1'b0;
                if (xfer) begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    skid_inst_d  = 32'h0;
                    skid_pc4_d   = 32'h0;
                    inst_d       = 32'h0;
                    inst_valid_d = 1'b0;
                    pc_d         = target;
                    state_d      = FETCH;
                end else if (consume) begin
                    inst_d       = skid_inst_q;
                    pc4_d        = skid_pc4_q;
                    inst_valid_d = 1'b1;
                    state_d      = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed literal scenarios plus a randomized run against a
// program-order model (which address decode must see next) and handshake/hold rules.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc;
    logic        id_stall;
    logic [31:0] pc, pc4, inst;
    logic        inst_valid;

    if_fetch_stage_if mem_if ();

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .id_stall   (id_stall),
        .imem       (mem_if.master),
        .pc         (pc),
        .pc4        (pc4),
        .inst       (inst),
        .inst_valid (inst_valid)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // reference state: address decode must consume next, plus one-cycle history
    logic [31:0] exp_addr  = RESET_PC;
    logic        pend_vld  = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic        hold_vld  = 1'b0;
    logic [31:0] hold_inst = 32'h0;
    logic [31:0] hold_pc4  = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    endtask

    // per-cycle compare against the model; called with inputs for the coming edge applied
    task automatic compare();
        logic cons;
        if (rst) chk("req_in_reset", {31'h0, mem_if.imem_req}, 32'h0);
        if (inst_valid === 1'b0) chk("bubble_inst_zero", inst, 32'h0);
        if (mem_if.imem_req === 1'b1) chk("addr_align", {30'h0, mem_if.imem_addr[1:0]}, 32'h0);
        if (pend_vld && !rst) begin
            chk("req_held", {31'h0, mem_if.imem_req}, 32'h1);
            chk("addr_held", mem_if.imem_addr, pend_addr);
        end
        if (hold_vld) begin
            chk("hold_valid", {31'h0, inst_valid}, 32'h1);
            chk("hold_inst", inst, hold_inst);
            chk("hold_pc4", pc4, hold_pc4);
        end
        cons = !rst && (inst_valid === 1'b1) && !id_stall;
        if (cons) begin
            chk("seq_inst", inst, mem_word(exp_addr));
            chk("seq_pc4", pc4, exp_addr + 32'd4);
            if (pcsource[0]) exp_addr = (pcsource[1] ? jpc : bpc) & 32'hFFFF_FFFC;
            else             exp_addr = exp_addr + 32'd4;
        end
        if (rst) exp_addr = RESET_PC;
        pend_vld  = !rst && (mem_if.imem_req === 1'b1) && !mem_if.imem_ready;
        pend_addr = mem_if.imem_addr;
        hold_vld  = !rst && (inst_valid === 1'b1) && id_stall;
        hold_inst = inst;
        hold_pc4  = pc4;
    endtask

    task automatic tick(input logic r, input logic rdy, input logic stl,
                        input logic [1:0] ps, input logic [31:0] b, input logic [31:0] j);
        @(negedge clk);
        rst                = r;
        mem_if.imem_ready  = rdy;
        id_stall           = stl;
        pcsource           = ps;
        bpc                = b;
        jpc                = j;
        #1;
        mem_if.imem_rdata  = mem_word(mem_if.imem_addr);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic rdy);
        tick(1'b0, rdy, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; id_stall = 1'b0; pcsource = 2'b00; bpc = 32'h0; jpc = 32'h0;
        mem_if.imem_ready = 1'b0; mem_if.imem_rdata = 32'h0;

        // reset values
        do_reset();
        chk("rst_pc", pc, RESET_PC);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc4", pc4, 32'h0);
        chk("rst_req", {31'h0, mem_if.imem_req}, 32'h0);

        // zero-wait streaming from RESET_PC
        go(1'b1);
        chk("stream0_inst", inst, 32'd0);
        chk("stream0_pc4", pc4, 32'd4);
        chk("stream0_addr", mem_if.imem_addr, 32'd4);
        go(1'b1);
        chk("stream1_inst", inst, 32'd1);
        chk("stream1_pc4", pc4, 32'd8);
        go(1'b1);
        chk("stream2_inst", inst, 32'd2);
        chk("stream2_pc4", pc4, 32'd12);

        // 4-cycle decode stall: exactly one fetch into the skid, then no requests
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
            chk("stall_inst", inst, 32'd2);
            chk("stall_req", {31'h0, mem_if.imem_req}, 32'h0);
            chk("stall_pc", pc, 32'h10);
        end
        go(1'b1);
        chk("release_inst", inst, 32'd3);
        chk("release_pc4", pc4, 32'h10);
        chk("release_addr", mem_if.imem_addr, 32'h10);
        go(1'b1);
        chk("release_next", inst, 32'd4);

        // taken branch at 0x10 with zero-wait memory: one bubble
        do_reset();
        for (int i = 0; i < 5; i++) go(1'b1);
        chk("br_at", pc4, 32'h14);
        tick(1'b0, 1'b1, 1'b0, 2'b01, 32'h100, 32'h0);
        chk("br_bubble", {31'h0, inst_valid}, 32'h0);
        chk("br_addr", mem_if.imem_addr, 32'h100);
        go(1'b1);
        chk("br_inst", inst, 32'h40);
        chk("br_pc4", pc4, 32'h104);

        // jump while fetch of 0x20 is outstanding: drain it, then fetch 0x200
        do_reset();
        for (int i = 0; i < 8; i++) go(1'b1);
        chk("jmp_pend_addr", mem_if.imem_addr, 32'h20);
        tick(1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 32'h200);
        chk("jmp_drain_addr", mem_if.imem_addr, 32'h20);
        chk("jmp_drain_valid", {31'h0, inst_valid}, 32'h0);
        go(1'b0);
        go(1'b0);
        chk("jmp_drain_addr2", mem_if.imem_addr, 32'h20);
        go(1'b1);
        chk("jmp_tgt_addr", mem_if.imem_addr, 32'h200);
        chk("jmp_stale_dropped", {31'h0, inst_valid}, 32'h0);
        go(1'b1);
        chk("jmp_inst", inst, 32'h80);
        chk("jmp_pc4", pc4, 32'h204);

        // reset asserted while in HOLD
        do_reset();
        go(1'b1);
        tick(1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
        chk("hold_entered", {31'h0, mem_if.imem_req}, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
        chk("hrst_valid", {31'h0, inst_valid}, 32'h0);
        chk("hrst_pc", pc, RESET_PC);
        go(1'b1);
        chk("hrst_inst", inst, 32'd0);
        chk("hrst_pc4", pc4, 32'd4);

        // PC wrap at the top of the address space
        tick(1'b0, 1'b1, 1'b0, 2'b11, 32'h0, 32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        go(1'b1);
        chk("wrap_inst", inst, 32'h3FFF_FFFF);
        chk("wrap_pc4", pc4, 32'h0);
        chk("wrap_pcnext", pc, 32'h0);
        go(1'b1);
        chk("wrap_after", inst, 32'd0);

        // ready every third cycle
        do_reset();
        for (int i = 0; i < 9; i++) begin
            go((i % 3) == 2);
            chk("slow_valid", {31'h0, inst_valid}, ((i % 3) == 2) ? 32'h1 : 32'h0);
        end

        // randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom % 200) == 0,
                 ($urandom % 3) != 0,
                 ($urandom % 4) == 0,
                 2'($urandom),
                 $urandom,
                 $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
